// File: rtl/scr_pkg.sv
// Shared constants for the txtd screen write path: bus widths, arbiter states, grant codes.
package scr_pkg;

    localparam int SCR_ADDR_W = 13;
    localparam int SCR_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

endpackage

// File: rtl/scr_wr_arbiter.sv
// Burst-granting round-robin arbiter sharing the txtd screen write port between
// the serial loader (port 0) and the torus renderer (port 1).
module scr_wr_arbiter
    import scr_pkg::*;
#(
    parameter int ADDR_W    = SCR_ADDR_W,
    parameter int DATA_W    = SCR_DATA_W,
    parameter int MAX_BURST = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              wr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state, state_nxt;
    logic             last_served;
    logic [CNT_W-1:0] beat_cnt;
    logic             xfer0, xfer1, burst_done;

    assign req0_ready = (state == GNT0) & ~reset;
    assign req1_ready = (state == GNT1) & ~reset;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    // The beat being transferred now is the MAX_BURST-th of this grant.
    assign burst_done = (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_comb begin
        state_nxt = state;
        grant     = GRANT_NONE;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_served))
                    state_nxt = GNT0;
                else if (req1_valid)
                    state_nxt = GNT1;
            end
            GNT0: begin
                grant = GRANT_P0;
                if (!req0_valid || req0_last || burst_done)
                    state_nxt = IDLE;
            end
            GNT1: begin
                grant = GRANT_P1;
                if (!req1_valid || req1_last || burst_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            beat_cnt    <= '0;
            wr          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
        end else begin
            state <= state_nxt;
            wr    <= xfer0 | xfer1;
            if (xfer0) begin
                waddr <= req0_addr;
                wdata <= req0_data;
            end else if (xfer1) begin
                waddr <= req1_addr;
                wdata <= req1_data;
            end
            // Counter is cleared while idle so every grant starts from zero.
            if (state == IDLE) begin
                beat_cnt <= '0;
                if (state_nxt == GNT0)
                    last_served <= 1'b0;
                else if (state_nxt == GNT1)
                    last_served <= 1'b1;
            end else if (xfer0 | xfer1) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scr_wr_arbiter.sv
// Directed + random bench for scr_wr_arbiter: two instances (MAX_BURST 4 and 1)
// share stimulus and are each compared every cycle against a behavioural model.
module tb_scr_wr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
    logic [12:0] a0 = '0, a1 = '0;
    logic [15:0] d0 = '0, d1 = '0;

    logic [1:0]       rdy0, rdy1, wr;
    logic [1:0][12:0] waddr;
    logic [1:0][15:0] wdata;
    logic [1:0][1:0]  grant;

    scr_wr_arbiter #(.ADDR_W(13), .DATA_W(16), .MAX_BURST(4)) u_mb4 (
        .clk(clk), .reset(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_last(l0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_last(l1), .req1_ready(rdy1[0]),
        .wr(wr[0]), .waddr(waddr[0]), .wdata(wdata[0]), .grant(grant[0])
    );

    scr_wr_arbiter #(.ADDR_W(13), .DATA_W(16), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .reset(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_last(l0), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_last(l1), .req1_ready(rdy1[1]),
        .wr(wr[1]), .waddr(waddr[1]), .wdata(wdata[1]), .grant(grant[1])
    );

    int checks = 0;
    int errors = 0;

    // Model: who owns the port (-1 none), who was served last, beats this grant,
    // and what the write port should show after the edge.
    int          m_owner[2];
    int          m_last[2];
    int          m_beats[2];
    logic        m_wr[2];
    logic [12:0] m_addr[2];
    logic [15:0] m_data[2];

    function automatic int mb_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k);
        logic vv, ll;
        if (rst) begin
            m_owner[k] = -1; m_last[k] = 1; m_beats[k] = 0;
            m_wr[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0;
        end else if (m_owner[k] < 0) begin
            m_wr[k] = 1'b0;
            if (v0 && v1) m_owner[k] = 1 - m_last[k];
            else if (v0)  m_owner[k] = 0;
            else if (v1)  m_owner[k] = 1;
            if (m_owner[k] >= 0) begin
                m_last[k]  = m_owner[k];
                m_beats[k] = 0;
            end
        end else begin
            vv = (m_owner[k] == 0) ? v0 : v1;
            ll = (m_owner[k] == 0) ? l0 : l1;
            m_wr[k] = vv;
            if (!vv) begin
                m_owner[k] = -1;
            end else begin
                m_addr[k] = (m_owner[k] == 0) ? a0 : a1;
                m_data[k] = (m_owner[k] == 0) ? d0 : d1;
                m_beats[k]++;
                if (ll || m_beats[k] == mb_of(k)) m_owner[k] = -1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready0[mb%0d]", mb_of(k)), 32'(rdy0[k]), 32'(m_owner[k] == 0 && !rst));
            chk($sformatf("ready1[mb%0d]", mb_of(k)), 32'(rdy1[k]), 32'(m_owner[k] == 1 && !rst));
            chk($sformatf("wr[mb%0d]", mb_of(k)),     32'(wr[k]),    32'(m_wr[k]));
            chk($sformatf("waddr[mb%0d]", mb_of(k)),  32'(waddr[k]), 32'(m_addr[k]));
            chk($sformatf("wdata[mb%0d]", mb_of(k)),  32'(wdata[k]), 32'(m_data[k]));
            chk($sformatf("grant[mb%0d]", mb_of(k)),  32'(grant[k]),
                (m_owner[k] == 0) ? 32'd1 : (m_owner[k] == 1) ? 32'd2 : 32'd0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic       x0, x1;
        int         b0, b1, n;
        logic [1:0] prev;
        logic [1:0] order[$];

        // Reset state
        do_reset();
        cyc();

        // Port 0 alone: 3-beat burst 0x100.., data 0xA1..
        b0 = 0; n = 0;
        v0 = 1'b1; a0 = 13'h100; d0 = 16'hA1; l0 = 1'b0;
        for (int i = 0; i < 12 && b0 < 3; i++) begin
            x0 = v0 && m_owner[0] == 0;
            cyc();
            if (wr[0]) n++;
            if (x0) begin
                b0++;
                a0 = 13'h100 + 13'(b0); d0 = 16'hA1 + 16'(b0); l0 = (b0 == 2);
                if (b0 == 3) v0 = 1'b0;
            end
        end
        cyc(); if (wr[0]) n++;
        cyc(); if (wr[0]) n++;
        chk("t1_write_count", 32'(n), 32'd3);
        chk("t1_grant_idle", 32'(grant[0]), 32'd0);

        // Both valid from reset release, 2-beat bursts: order 0,1,0,1
        rst = 1'b1; cyc();
        b0 = 0; b1 = 0; prev = 2'b00;
        v0 = 1'b1; a0 = 13'h200; d0 = 16'h2000; l0 = 1'b0;
        v1 = 1'b1; a1 = 13'h300; d1 = 16'h3000; l1 = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            x0 = m_owner[0] == 0;
            x1 = m_owner[0] == 1;
            cyc();
            if (grant[0] != 2'b00 && prev == 2'b00) order.push_back(grant[0]);
            prev = grant[0];
            if (x0) begin b0++; a0 = 13'h200 + 13'(b0); d0 = 16'h2000 + 16'(b0); l0 = b0[0]; end
            if (x1) begin b1++; a1 = 13'h300 + 13'(b1); d1 = 16'h3000 + 16'(b1); l1 = b1[0]; end
        end
        chk("t2_bursts_seen", 32'(order.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_order%0d", i), 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // Port 1 never sets last; forced release after 4 beats, then port 0
        do_reset();
        b1 = 0; n = 0;
        v1 = 1'b1; a1 = 13'h400; d1 = 16'h4000; l1 = 1'b0;
        cyc();
        v0 = 1'b1; a0 = 13'h480; d0 = 16'h4800; l0 = 1'b1;
        for (int i = 0; i < 20 && grant[0] != 2'b01; i++) begin
            x1 = m_owner[0] == 1;
            cyc();
            if (wr[0]) n++;
            if (x1) begin b1++; a1 = 13'h400 + 13'(b1); d1 = 16'h4000 + 16'(b1); end
        end
        chk("t3_forced_beats", 32'(n), 32'd4);
        chk("t3_port0_granted", 32'(grant[0]), 32'd1);

        // Port 0 drops valid after 2 beats, then port 1 requests
        do_reset();
        b0 = 0; n = 0;
        v0 = 1'b1; a0 = 13'h500; d0 = 16'h5000; l0 = 1'b0;
        a1 = 13'h600; d1 = 16'h6000; l1 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            x0 = v0 && m_owner[0] == 0;
            cyc();
            if (wr[0] && waddr[0][12:8] == 5'h05) n++;
            if (x0) begin
                b0++; a0 = 13'h500 + 13'(b0);
                if (b0 == 2) begin v0 = 1'b0; v1 = 1'b1; end
            end
            if (m_owner[0] == 1) v1 = 1'b0;
        end
        chk("t4_port0_writes", 32'(n), 32'd2);

        // Reset while in GNT1 after one beat; next tie goes to port 0
        do_reset();
        v1 = 1'b1; a1 = 13'h700; d1 = 16'h7777; l1 = 1'b0;
        cyc();
        cyc();
        chk("t5_beat_emitted", 32'(wr[0]), 32'd1);
        chk("t5_beat_addr", 32'(waddr[0]), 32'h700);
        rst = 1'b1;
        cyc();
        chk("t5_wr_after_rst", 32'(wr[0]), 32'd0);
        chk("t5_grant_after_rst", 32'(grant[0]), 32'd0);
        rst = 1'b0; v0 = 1'b1; a0 = 13'h710; d0 = 16'h7100; l0 = 1'b1;
        cyc();
        chk("t5_tie_port0", 32'(grant[0]), 32'd1);
        v0 = 1'b0; v1 = 1'b0;
        cyc(); cyc();

        // Port 0 waits with stable beat while port 1 owns: accepted exactly once
        do_reset();
        b1 = 0; n = 0;
        v1 = 1'b1; a1 = 13'h880; d1 = 16'h8800; l1 = 1'b0;
        cyc();
        v0 = 1'b1; a0 = 13'h800; d0 = 16'hBEEF; l0 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            x0 = v0 && m_owner[0] == 0;
            x1 = v1 && m_owner[0] == 1;
            cyc();
            if (wr[0] && waddr[0] == 13'h800) n++;
            if (x0) v0 = 1'b0;
            if (x1) begin
                b1++; a1 = 13'h880 + 13'(b1); l1 = (b1 == 2);
                if (b1 == 3) v1 = 1'b0;
            end
        end
        chk("t6_single_accept", 32'(n), 32'd1);

        // Random traffic, both instances against the model every cycle
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            v0 = ($urandom_range(3) != 0);
            v1 = ($urandom_range(3) != 0);
            l0 = ($urandom_range(3) == 0);
            l1 = ($urandom_range(3) == 0);
            a0 = 13'($urandom); d0 = 16'($urandom);
            a1 = 13'($urandom); d1 = 16'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
